// File: rtl/match_scorer.sv
// rtl/match_scorer.sv - two-team set/match scorer with frozen set-end display and optional one-deep undo
//
// Purpose : counts points per set, awards sets on (target, lead-by-2), freezes the final
//           set score for HOLD_CYCLES cycles, then starts the next set or declares a winner.
// Macro   : SCORER_UNDO_EN - when defined, keeps a one-deep record of the last accepted
//           point so iUNDO can revoke it; when undefined iUNDO is ignored and no record exists.
// Ports   : iCLK      - clock, rising edge
//           iRST      - asynchronous active-high reset
//           iPOINT1/2 - single-cycle point pulses per team
//           iUNDO     - single-cycle undo pulse (SCORER_UNDO_EN only)
//           oSCORE1/2 - points in the current set (0..99)
//           oSETS1/2  - sets won
//           oSET_END  - high while the finished set score is frozen
//           win1/win2 - match winner flags (mutually exclusive)

module match_scorer #(
    parameter int SET_POINTS   = 25,
    parameter int FINAL_POINTS = 15,
    parameter int SETS_TO_WIN  = 3,
    parameter int HOLD_CYCLES  = 50000000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iPOINT1,
    input  logic       iPOINT2,
    input  logic       iUNDO,
    output logic [6:0] oSCORE1,
    output logic [6:0] oSCORE2,
    output logic [1:0] oSETS1,
    output logic [1:0] oSETS2,
    output logic       oSET_END,
    output logic       win1,
    output logic       win2
);

    localparam int HOLD_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [2:0] FINAL_SUM = 3'(2 * SETS_TO_WIN - 2);
    localparam logic [6:0] SET_TGT   = 7'(SET_POINTS);
    localparam logic [6:0] FINAL_TGT = 7'(FINAL_POINTS);
    localparam logic [1:0] SETS_WIN  = 2'(SETS_TO_WIN);
    localparam logic [6:0] MAX_SCORE = 7'd99;

    typedef enum logic [1:0] {S_PLAY, S_SET_END, S_MATCH_END} state_t;

    state_t            r_state, w_state;
    logic [6:0]        r_score1, r_score2, w_score1, w_score2;
    logic [1:0]        r_sets1, r_sets2, w_sets1, w_sets2;
    logic [HOLD_W-1:0] r_hold, w_hold;
    logic              r_set_end, w_set_end;
    logic              r_win1, r_win2, w_win1, w_win2;

    logic       w_pt1, w_pt2;
    logic [6:0] w_target;
    logic       w_undo_hit;
    logic       w_undo_team;     // 0 = team 1, 1 = team 2
    logic       w_acc1, w_acc2;  // point accepted without ending the set
    logic       w_set_won;

    // Simultaneous pulses cancel each other.
    assign w_pt1 = iPOINT1 & ~iPOINT2;
    assign w_pt2 = iPOINT2 & ~iPOINT1;

    assign w_target = (({1'b0, r_sets1} + {1'b0, r_sets2}) == FINAL_SUM) ? FINAL_TGT : SET_TGT;

`ifdef SCORER_UNDO_EN
    logic r_undo_vld, r_undo_team;

    assign w_undo_hit  = iUNDO & r_undo_vld & (r_state == S_PLAY);
    assign w_undo_team = r_undo_team;

    // The record only ever describes a point that did not end a set.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_undo_vld  <= 1'b0;
            r_undo_team <= 1'b0;
        end else if (r_state == S_PLAY) begin
            if (w_undo_hit || w_set_won) begin
                r_undo_vld <= 1'b0;
            end else if (w_acc1) begin
                r_undo_vld  <= 1'b1;
                r_undo_team <= 1'b0;
            end else if (w_acc2) begin
                r_undo_vld  <= 1'b1;
                r_undo_team <= 1'b1;
            end
        end
    end
`else
    logic w_unused_undo;

    assign w_undo_hit    = 1'b0;
    assign w_undo_team   = 1'b0;
    assign w_unused_undo = iUNDO;
`endif

    always_comb begin
        w_state   = r_state;
        w_score1  = r_score1;
        w_score2  = r_score2;
        w_sets1   = r_sets1;
        w_sets2   = r_sets2;
        w_hold    = r_hold;
        w_win1    = r_win1;
        w_win2    = r_win2;
        w_acc1    = 1'b0;
        w_acc2    = 1'b0;
        w_set_won = 1'b0;

        case (r_state)
            S_PLAY: begin
                if (w_undo_hit) begin
                    // A valid undo outranks any coincident point.
                    if (w_undo_team) begin
                        if (r_score2 != 7'd0) w_score2 = r_score2 - 7'd1;
                    end else begin
                        if (r_score1 != 7'd0) w_score1 = r_score1 - 7'd1;
                    end
                end else if (w_pt1 && (r_score1 != MAX_SCORE)) begin
                    w_score1 = r_score1 + 7'd1;
                    if ((w_score1 >= w_target) && (w_score1 >= r_score2 + 7'd2)) begin
                        w_sets1   = r_sets1 + 2'd1;
                        w_state   = S_SET_END;
                        w_hold    = '0;
                        w_set_won = 1'b1;
                    end else begin
                        w_acc1 = 1'b1;
                    end
                end else if (w_pt2 && (r_score2 != MAX_SCORE)) begin
                    w_score2 = r_score2 + 7'd1;
                    if ((w_score2 >= w_target) && (w_score2 >= r_score1 + 7'd2)) begin
                        w_sets2   = r_sets2 + 2'd1;
                        w_state   = S_SET_END;
                        w_hold    = '0;
                        w_set_won = 1'b1;
                    end else begin
                        w_acc2 = 1'b1;
                    end
                end
            end
            S_SET_END: begin
                if (r_hold == HOLD_LAST) begin
                    w_score1 = 7'd0;
                    w_score2 = 7'd0;
                    w_hold   = '0;
                    if (r_sets1 == SETS_WIN) begin
                        w_state = S_MATCH_END;
                        w_win1  = 1'b1;
                    end else if (r_sets2 == SETS_WIN) begin
                        w_state = S_MATCH_END;
                        w_win2  = 1'b1;
                    end else begin
                        w_state = S_PLAY;
                    end
                end else begin
                    w_hold = r_hold + 1'b1;
                end
            end
            S_MATCH_END: begin
                // Terminal until reset.
            end
            default: begin
                w_state = S_PLAY;
            end
        endcase

        w_set_end = (w_state == S_SET_END);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state   <= S_PLAY;
            r_score1  <= 7'd0;
            r_score2  <= 7'd0;
            r_sets1   <= 2'd0;
            r_sets2   <= 2'd0;
            r_hold    <= '0;
            r_set_end <= 1'b0;
            r_win1    <= 1'b0;
            r_win2    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_score1  <= w_score1;
            r_score2  <= w_score2;
            r_sets1   <= w_sets1;
            r_sets2   <= w_sets2;
            r_hold    <= w_hold;
            r_set_end <= w_set_end;
            r_win1    <= w_win1;
            r_win2    <= w_win2;
        end
    end

    assign oSCORE1  = r_score1;
    assign oSCORE2  = r_score2;
    assign oSETS1   = r_sets1;
    assign oSETS2   = r_sets2;
    assign oSET_END = r_set_end;
    assign win1     = r_win1;
    assign win2     = r_win2;

endmodule
